// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - pipeline hazard info in, stage control and PC enable out
interface pipeline_hazard_controller_if;

  typedef struct packed {
    logic [1:0] rs1mux_sel;
    logic [1:0] rs2mux_sel;
    logic       pipe_load_ifid;
    logic       pipe_load_idex;
    logic       pipe_load_exmem;
    logic       pipe_load_memwb;
    logic       pipe_rst_ifid;
    logic       pipe_rst_idex;
    logic       pipe_rst_exmem;
    logic       pipe_rst_memwb;
  } control_t;

  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic [4:0] idex_rs1;
  logic [4:0] idex_rs2;
  logic [4:0] idex_rd;
  logic       idex_dcache_read;
  logic [4:0] exmem_rd;
  logic       exmem_load_regfile;
  logic [4:0] memwb_rd;
  logic       memwb_load_regfile;
  logic       br_taken;
  logic       icache_stall;
  logic       dcache_stall;
  control_t   ctrl;
  logic       pc_load;

  modport master (
    output ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, idex_dcache_read,
    output exmem_rd, exmem_load_regfile, memwb_rd, memwb_load_regfile,
    output br_taken, icache_stall, dcache_stall,
    input  ctrl, pc_load
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, idex_dcache_read,
    input  exmem_rd, exmem_load_regfile, memwb_rd, memwb_load_regfile,
    input  br_taken, icache_stall, dcache_stall,
    output ctrl, pc_load
  );

endinterface

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/bubble sequencing, forwarding selects and perf counters
module pipeline_hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_hazard_controller_if.slave bus,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt,
  output logic [CNT_W-1:0]            bubble_cnt
);

  typedef enum logic {
    RUN       = 1'b0,
    MEM_STALL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             flush_pending_q, flush_pending_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic       mem_stall;
  logic       flush;
  logic       load_use;
  logic [1:0] rs1_sel;
  logic [1:0] rs2_sel;
  logic [3:0] loads;
  logic [3:0] resets;
  logic       pc_ld;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] ex_rd,
    input logic       ex_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    if (ex_we && (ex_rd != 5'd0) && (ex_rd == rs)) return 2'b01;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A branch seen while stalled is remembered so exactly one flush lands on release.
  assign mem_stall = bus.icache_stall | bus.dcache_stall;
  assign flush     = bus.br_taken | flush_pending_q;
  assign load_use  = bus.idex_dcache_read && (bus.idex_rd != 5'd0) &&
                     ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      flush_pending_q <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
      bubble_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      bubble_cnt_q    <= bubble_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    bubble_cnt_d    = bubble_cnt_q;
    case (state_q)
      RUN:       if (mem_stall)  state_d = MEM_STALL;
      MEM_STALL: if (!mem_stall) state_d = RUN;
      default:                   state_d = RUN;
    endcase
    if (mem_stall) begin
      flush_pending_d = flush_pending_q | bus.br_taken;
      stall_cnt_d     = sat_inc(stall_cnt_q);
    end else begin
      flush_pending_d = 1'b0;
      if (flush)         flush_cnt_d  = sat_inc(flush_cnt_q);
      else if (load_use) bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  // loads/resets bit order: {ifid, idex, exmem, memwb}
  always_comb begin
    rs1_sel = 2'b00;
    rs2_sel = 2'b00;
    loads   = 4'b1111;
    resets  = 4'b0000;
    pc_ld   = 1'b1;
    if (rst) begin
      loads  = 4'b0000;
      resets = 4'b1111;
      pc_ld  = 1'b0;
    end else begin
      rs1_sel = fwd_sel(bus.idex_rs1, bus.exmem_rd, bus.exmem_load_regfile,
                        bus.memwb_rd, bus.memwb_load_regfile);
      rs2_sel = fwd_sel(bus.idex_rs2, bus.exmem_rd, bus.exmem_load_regfile,
                        bus.memwb_rd, bus.memwb_load_regfile);
      if (mem_stall) begin
        loads = 4'b0000;
        pc_ld = 1'b0;
      end else if (flush) begin
        resets = 4'b1100;
      end else if (load_use) begin
        loads  = 4'b0111;
        resets = 4'b0100;
        pc_ld  = 1'b0;
      end
    end
  end

  assign bus.ctrl    = {rs1_sel, rs2_sel, loads, resets};
  assign bus.pc_load = pc_ld;

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - random and directed checks against a behavioural hazard model
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if bus_a ();
  pipeline_hazard_controller_if bus_b ();

  logic [31:0] sc_a, fc_a, bc_a;
  logic [3:0]  sc_b, fc_b, bc_b;

  pipeline_hazard_controller #(.CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .stall_cnt(sc_a), .flush_cnt(fc_a), .bubble_cnt(bc_a)
  );

  pipeline_hazard_controller #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .stall_cnt(sc_b), .flush_cnt(fc_b), .bubble_cnt(bc_b)
  );

  assign bus_b.ifid_rs1           = bus_a.ifid_rs1;
  assign bus_b.ifid_rs2           = bus_a.ifid_rs2;
  assign bus_b.idex_rs1           = bus_a.idex_rs1;
  assign bus_b.idex_rs2           = bus_a.idex_rs2;
  assign bus_b.idex_rd            = bus_a.idex_rd;
  assign bus_b.idex_dcache_read   = bus_a.idex_dcache_read;
  assign bus_b.exmem_rd           = bus_a.exmem_rd;
  assign bus_b.exmem_load_regfile = bus_a.exmem_load_regfile;
  assign bus_b.memwb_rd           = bus_a.memwb_rd;
  assign bus_b.memwb_load_regfile = bus_a.memwb_load_regfile;
  assign bus_b.br_taken           = bus_a.br_taken;
  assign bus_b.icache_stall       = bus_a.icache_stall;
  assign bus_b.dcache_stall       = bus_a.dcache_stall;

  int     n_tests;
  int     n_fail;
  bit     m_pend;
  longint m_stall, m_flush, m_bubble;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint capped(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (bus_a.exmem_load_regfile && bus_a.exmem_rd != 0 && bus_a.exmem_rd == rs) return 2'b01;
    if (bus_a.memwb_load_regfile && bus_a.memwb_rd != 0 && bus_a.memwb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_hazard();
    return bus_a.idex_dcache_read && bus_a.idex_rd != 0 &&
           (bus_a.idex_rd == bus_a.ifid_rs1 || bus_a.idex_rd == bus_a.ifid_rs2);
  endfunction

  // Expected ctrl as {rs1, rs2, load ifid/idex/exmem/memwb, rst ifid/idex/exmem/memwb}
  task automatic ref_outputs(output logic [11:0] c, output logic p);
    bit stall;
    stall = bus_a.icache_stall | bus_a.dcache_stall;
    if (rst) begin
      c = {2'b00, 2'b00, 4'b0000, 4'b1111};
      p = 1'b0;
    end else if (stall) begin
      c = {ref_fwd(bus_a.idex_rs1), ref_fwd(bus_a.idex_rs2), 4'b0000, 4'b0000};
      p = 1'b0;
    end else if (bus_a.br_taken || m_pend) begin
      c = {ref_fwd(bus_a.idex_rs1), ref_fwd(bus_a.idex_rs2), 4'b1111, 4'b1100};
      p = 1'b1;
    end else if (ref_hazard()) begin
      c = {ref_fwd(bus_a.idex_rs1), ref_fwd(bus_a.idex_rs2), 4'b0111, 4'b0100};
      p = 1'b0;
    end else begin
      c = {ref_fwd(bus_a.idex_rs1), ref_fwd(bus_a.idex_rs2), 4'b1111, 4'b0000};
      p = 1'b1;
    end
  endtask

  task automatic cycle();
    logic [11:0] ec;
    logic        ep;
    bit          stall, fl, hz, r;
    #1;
    ref_outputs(ec, ep);
    check("ctrl_a", bus_a.ctrl, ec);
    check("pc_a", bus_a.pc_load, ep);
    check("ctrl_b", bus_b.ctrl, ec);
    check("pc_b", bus_b.pc_load, ep);
    r     = rst;
    stall = bus_a.icache_stall | bus_a.dcache_stall;
    fl    = bus_a.br_taken | m_pend;
    hz    = ref_hazard();
    @(posedge clk);
    if (r) begin
      m_pend = 0; m_stall = 0; m_flush = 0; m_bubble = 0;
    end else if (stall) begin
      m_pend = m_pend | bus_a.br_taken;
      m_stall++;
    end else begin
      m_pend = 0;
      if (fl)      m_flush++;
      else if (hz) m_bubble++;
    end
    #1;
    check("stall_a", sc_a, capped(m_stall, 32));
    check("flush_a", fc_a, capped(m_flush, 32));
    check("bubble_a", bc_a, capped(m_bubble, 32));
    check("stall_b", sc_b, capped(m_stall, 4));
    check("flush_b", fc_b, capped(m_flush, 4));
    check("bubble_b", bc_b, capped(m_bubble, 4));
    @(negedge clk);
  endtask

  task automatic idle();
    bus_a.ifid_rs1 = 0; bus_a.ifid_rs2 = 0; bus_a.idex_rs1 = 0; bus_a.idex_rs2 = 0;
    bus_a.idex_rd = 0; bus_a.idex_dcache_read = 0;
    bus_a.exmem_rd = 0; bus_a.exmem_load_regfile = 0;
    bus_a.memwb_rd = 0; bus_a.memwb_load_regfile = 0;
    bus_a.br_taken = 0; bus_a.icache_stall = 0; bus_a.dcache_stall = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); cycle(); rst = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_pend = 0; m_stall = 0; m_flush = 0; m_bubble = 0;
    rst = 1; idle();
    @(negedge clk);

    // two reset cycles then idle
    #1;
    check("rst_pipe_rst", {bus_a.ctrl.pipe_rst_ifid, bus_a.ctrl.pipe_rst_idex,
                           bus_a.ctrl.pipe_rst_exmem, bus_a.ctrl.pipe_rst_memwb}, 4'b1111);
    check("rst_pc_load", bus_a.pc_load, 1'b0);
    cycle(); cycle();
    rst = 0;
    cycle();
    #1;
    check("idle_loads", {bus_a.ctrl.pipe_load_ifid, bus_a.ctrl.pipe_load_idex,
                         bus_a.ctrl.pipe_load_exmem, bus_a.ctrl.pipe_load_memwb}, 4'b1111);
    check("idle_rsts", {bus_a.ctrl.pipe_rst_ifid, bus_a.ctrl.pipe_rst_idex,
                        bus_a.ctrl.pipe_rst_exmem, bus_a.ctrl.pipe_rst_memwb}, 4'b0000);
    check("idle_cnts", {sc_a, fc_a}, 64'd0);
    cycle();

    // load-use bubble
    do_reset();
    bus_a.idex_dcache_read = 1; bus_a.idex_rd = 5; bus_a.ifid_rs1 = 5;
    #1;
    check("lu_load_ifid", bus_a.ctrl.pipe_load_ifid, 1'b0);
    check("lu_rst_idex", bus_a.ctrl.pipe_rst_idex, 1'b1);
    cycle();
    idle();
    #1;
    check("lu_bubble_cnt", bc_a, 32'd1);
    check("lu_after_load_ifid", bus_a.ctrl.pipe_load_ifid, 1'b1);
    cycle();

    // 4-cycle dcache stall with a branch in stall cycle 2
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus_a.dcache_stall = 1; bus_a.br_taken = (i == 2);
      cycle();
    end
    idle();
    #1;
    check("st_flush_rst_ifid", bus_a.ctrl.pipe_rst_ifid, 1'b1);
    cycle();
    check("st_stall_cnt", sc_a, 32'd4);
    check("st_flush_cnt", fc_a, 32'd1);
    cycle();
    check("st_flush_once", fc_a, 32'd1);

    // branch held high across stall and release
    do_reset();
    bus_a.br_taken = 1; bus_a.icache_stall = 1;
    cycle(); cycle(); cycle();
    bus_a.icache_stall = 0;
    cycle();
    bus_a.br_taken = 0;
    cycle();
    check("held_br_flush_cnt", fc_a, 32'd1);

    // branch and load-use in the same cycle
    do_reset();
    bus_a.br_taken = 1; bus_a.idex_dcache_read = 1; bus_a.idex_rd = 9; bus_a.ifid_rs2 = 9;
    cycle();
    idle();
    check("br_lu_flush", fc_a, 32'd1);
    check("br_lu_bubble", bc_a, 32'd0);

    // forwarding priority and x0
    do_reset();
    bus_a.exmem_rd = 7; bus_a.memwb_rd = 7; bus_a.exmem_load_regfile = 1;
    bus_a.memwb_load_regfile = 1; bus_a.idex_rs2 = 7;
    #1;
    check("fwd_rs2_ex", bus_a.ctrl.rs2mux_sel, 2'b01);
    cycle();
    bus_a.exmem_load_regfile = 0;
    #1;
    check("fwd_rs2_wb", bus_a.ctrl.rs2mux_sel, 2'b10);
    cycle();
    bus_a.exmem_load_regfile = 1; bus_a.exmem_rd = 0; bus_a.memwb_rd = 0; bus_a.idex_rs2 = 0;
    #1;
    check("fwd_rs2_x0", bus_a.ctrl.rs2mux_sel, 2'b00);
    cycle();
    idle();

    // reset drops a pending flush
    do_reset();
    bus_a.dcache_stall = 1; bus_a.br_taken = 1;
    cycle();
    idle(); rst = 1;
    cycle();
    rst = 0;
    cycle();
    check("rst_drop_flush", fc_a, 32'd0);

    // 4-bit stall counter saturation
    do_reset();
    bus_a.dcache_stall = 1;
    for (int i = 0; i < 15; i++) cycle();
    check("sat_reach", sc_b, 4'hF);
    for (int i = 0; i < 3; i++) cycle();
    check("sat_hold", sc_b, 4'hF);
    check("sat_wide", sc_a, 32'd18);
    idle();
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst                      = ($urandom_range(0, 99) < 2);
      bus_a.ifid_rs1           = 5'($urandom_range(0, 7));
      bus_a.ifid_rs2           = 5'($urandom_range(0, 7));
      bus_a.idex_rs1           = 5'($urandom_range(0, 7));
      bus_a.idex_rs2           = 5'($urandom_range(0, 7));
      bus_a.idex_rd            = 5'($urandom_range(0, 7));
      bus_a.idex_dcache_read   = 1'($urandom_range(0, 1));
      bus_a.exmem_rd           = 5'($urandom_range(0, 7));
      bus_a.exmem_load_regfile = 1'($urandom_range(0, 1));
      bus_a.memwb_rd           = 5'($urandom_range(0, 7));
      bus_a.memwb_load_regfile = 1'($urandom_range(0, 1));
      bus_a.br_taken           = ($urandom_range(0, 99) < 15);
      bus_a.icache_stall       = ($urandom_range(0, 99) < 15);
      bus_a.dcache_stall       = ($urandom_range(0, 99) < 15);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
